stb_dcache_responder: RTL and testbench
=======================================

Name: stb_dcache_responder

Overview:
Dcache-side responder for the store-buffer drain interface. It accepts one store at a time from the store buffer, updates a direct-mapped, one-word-per-line data array, forwards every store write-through to the memory bus, and then returns a single-cycle ack to the store buffer. A registered lookup port lets the LSU read the array (hit flag plus data).

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width
BYTE_SEL_WIDTH, 4, byte enables (DATA_WIDTH/8)
NUM_LINES, 16, direct-mapped lines (power of 2), one word each

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stb2dcache_addr  in  ADDR_WIDTH  store byte address; [1:0] ignored
stb2dcache_wdata  in  DATA_WIDTH  store data
stb2dcache_sel_byte  in  BYTE_SEL_WIDTH  byte enables
stb2dcache_w_en  in  1  write request when 1
stb2dcache_req  in  1  request valid; held by store buffer until ack
dmem_sel_i  in  1  request targets data memory
dcache2stb_ack  out  1  one-cycle completion pulse
dcache2mem_addr  out  ADDR_WIDTH  write-through address (word aligned)
dcache2mem_wdata  out  DATA_WIDTH  write-through data
dcache2mem_sel_byte  out  BYTE_SEL_WIDTH  write-through byte enables
dcache2mem_req  out  1  write-through request, held until mem2dcache_ack
mem2dcache_ack  in  1  memory accepted write
lsu2dcache_lk_addr  in  ADDR_WIDTH  lookup byte address
dcache2lsu_lk_hit  out  1  registered lookup hit
dcache2lsu_lk_rdata  out  DATA_WIDTH  registered lookup data
dcache2stb_busy  out  1  1 whenever FSM is not IDLE

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Address split: IDX_W = log2(NUM_LINES). Index = addr[IDX_W+1:2]. Tag = addr[ADDR_WIDTH-1:IDX_W+2].
- Reset:
  - All valid bits cleared.
  - FSM set to IDLE.
  - All outputs 0: dcache2stb_ack, dcache2mem_req, the dcache2mem_* buses, lk_hit, lk_rdata, busy.
  - Data and tag arrays are not reset.
- FSM states: IDLE, LOOKUP, MEM_WR, ACK.
  - IDLE: if stb2dcache_req=1, latch addr/wdata/sel/w_en/dmem_sel into a request register and go to LOOKUP. Otherwise stay.
  - LOOKUP: if the latched w_en=0 or dmem_sel=0, go to ACK (no array or memory effect). Otherwise compare tags:
    - Hit: merge the enabled bytes into the stored word.
    - Miss with sel_byte all ones: allocate the line (write tag and data, set valid).
    - Miss with partial sel_byte: no allocate, array unchanged.
    - In all three cases, go to MEM_WR.
  - MEM_WR: dcache2mem_req=1 with the latched addr (bits [1:0] forced to 0), data and sel. Bus values stay stable until mem2dcache_ack=1 is sampled; then drop req and go to ACK.
  - ACK: dcache2stb_ack=1 for exactly one cycle, then go to IDLE.
- Requests are never accepted in LOOKUP, MEM_WR or ACK; stb2dcache_req is ignored there.
- A req sampled in IDLE is always a new store, because the store buffer updates on the ack edge.
- Latency:
  - req sampled at cycle 0; LOOKUP at cycle 1; MEM_WR from cycle 2.
  - With mem ack sampled at cycle k (k>=2), the ack pulse is at cycle k+1.
  - Minimum store latency is 4 cycles. A non-write request acks at cycle 2.
- Lookup port: lk_hit and lk_rdata are registered from lsu2dcache_lk_addr one cycle later.
  - A same-cycle array update in LOOKUP is not visible (read-before-write); it is visible the following cycle.
  - On a miss, lk_rdata = 0.
- Reset mid-operation: the FSM returns to IDLE, dcache2mem_req and ack drop the next cycle, the in-flight store is discarded, and valid bits are cleared.
- sel_byte=0000 write: no byte changes and no allocate, but the write-through and ack still occur.

Decomposition:
- Package stb_dcache_pkg holds:
  - the typedef enum for the FSM states;
  - a packed struct for the request register (addr, wdata, sel, w_en, dmem_sel);
  - the IDX_W/TAG_W localparam functions.
- One sub-module, dcache_word_array: tag/valid/data storage with one byte-enabled write port and one registered read port returning hit and data.

Test Plan:
- Reset, lookup 0x0 -> lk_hit=0, lk_rdata=0; all outputs 0.
- Full-word store 0x0=AAAA_BBBB, mem ack on first MEM_WR cycle -> mem req at cycle 2 with addr 0x0, stb ack at cycle 3; lookup 0x0 -> hit, AAAA_BBBB.
- Partial store 0x4=CCCC_DDDD sel 0011 on an invalid line -> write-through issued; lookup 0x4 -> miss. Then full store 0x4=1111_2222, then sel 0100 data 00EE_0000 -> lookup returns 11EE_2222.
- Conflict: full store 0x40=DEAD_BEEF after 0x0 -> lookup 0x0 misses; lookup 0x40 hits DEAD_BEEF.
- Memory stall: mem2dcache_ack delayed 5 cycles -> dcache2mem_req and buses stable for 5 cycles, single ack pulse after; a new req held in that window is not accepted early.
- rst asserted in MEM_WR -> mem req low next cycle, no stb ack, all lookups miss afterwards; w_en=0 request acks at cycle 2 with no mem req.

Source files
------------

// File: rtl/stb_dcache_pkg.sv
// stb_dcache_pkg: shared types and address-split helpers for the store-buffer dcache responder
package stb_dcache_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_WR, S_ACK} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic          w_en;
    logic          dmem_sel;
  } req_t;
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int addr_width, input int num_lines);
    return addr_width - $clog2(num_lines) - 2;
  endfunction
endpackage

// File: rtl/dcache_word_array.sv
// dcache_word_array: direct-mapped one-word lines; byte-enabled store port and registered lookup
module dcache_word_array
  import stb_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int NUM_LINES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr,
  input  logic [ADDR_WIDTH-3:0]     i_wr_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic [BYTE_SEL_WIDTH-1:0] i_wr_sel,
  input  logic [ADDR_WIDTH-3:0]     i_rd_waddr,
  output logic                      o_rd_hit,
  output logic [DATA_WIDTH-1:0]     o_rd_data
);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(ADDR_WIDTH, NUM_LINES);
  logic [TW-1:0]         r_tag  [NUM_LINES];
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid;
  logic                  r_rd_hit;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [IW-1:0]         w_wi, w_ri;
  logic [TW-1:0]         w_wt, w_rt;
  logic                  w_wr_hit, w_alloc, w_rd_hit;
  logic [DATA_WIDTH-1:0] w_merged;
  assign w_wi = i_wr_waddr[IW-1:0];
  assign w_wt = i_wr_waddr[ADDR_WIDTH-3:IW];
  assign w_ri = i_rd_waddr[IW-1:0];
  assign w_rt = i_rd_waddr[ADDR_WIDTH-3:IW];
  assign w_wr_hit = r_valid[w_wi] && r_tag[w_wi] == w_wt;
  // only a full-word store may claim a line it misses on
  assign w_alloc = !w_wr_hit && &i_wr_sel;
  assign w_rd_hit = r_valid[w_ri] && r_tag[w_ri] == w_rt;
  always_comb begin
    w_merged = r_data[w_wi];
    for (int b = 0; b < BYTE_SEL_WIDTH; b++)
      w_merged[8*b+:8] = i_wr_sel[b] ? i_wr_data[8*b+:8] : r_data[w_wi][8*b+:8];
  end
  always_ff @(posedge clk)
    if (i_wr && (w_wr_hit || w_alloc)) begin
      r_data[w_wi] <= w_merged;
      r_tag[w_wi]  <= w_wt;
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_valid   <= '0;
      r_rd_hit  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (i_wr && w_alloc) r_valid[w_wi] <= 1'b1;
      r_rd_hit  <= w_rd_hit;
      r_rd_data <= w_rd_hit ? r_data[w_ri] : '0;
    end
  assign o_rd_hit  = r_rd_hit;
  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/stb_dcache_responder.sv
// stb_dcache_responder: drains one store at a time into the word array, writes it through to memory, then acks
module stb_dcache_responder
  import stb_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int DATA_WIDTH = DW,
  parameter int BYTE_SEL_WIDTH = SW,
  parameter int NUM_LINES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  input  logic                      stb2dcache_w_en,
  input  logic                      stb2dcache_req,
  input  logic                      dmem_sel_i,
  output logic                      dcache2stb_ack,
  output logic [ADDR_WIDTH-1:0]     dcache2mem_addr,
  output logic [DATA_WIDTH-1:0]     dcache2mem_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte,
  output logic                      dcache2mem_req,
  input  logic                      mem2dcache_ack,
  input  logic [ADDR_WIDTH-1:0]     lsu2dcache_lk_addr,
  output logic                      dcache2lsu_lk_hit,
  output logic [DATA_WIDTH-1:0]     dcache2lsu_lk_rdata,
  output logic                      dcache2stb_busy
);
  state_t r_state, w_next;
  req_t   r_req;
  logic   w_is_wr, w_mem, w_unused;
  assign w_unused = ^{stb2dcache_addr[1:0], lsu2dcache_lk_addr[1:0]};
  assign w_is_wr  = r_req.w_en && r_req.dmem_sel;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && stb2dcache_req)
        r_req <= '{addr: {stb2dcache_addr[ADDR_WIDTH-1:2], 2'b00}, wdata: stb2dcache_wdata,
                   sel: stb2dcache_sel_byte, w_en: stb2dcache_w_en, dmem_sel: dmem_sel_i};
    end
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE   ? (stb2dcache_req ? S_LOOKUP : S_IDLE) :
             r_state == S_LOOKUP ? (w_is_wr ? S_MEM_WR : S_ACK) :
             r_state == S_MEM_WR ? (mem2dcache_ack ? S_ACK : S_MEM_WR) : S_IDLE;
    w_mem               = r_state == S_MEM_WR;
    dcache2mem_req      = w_mem;
    dcache2mem_addr     = w_mem ? r_req.addr : '0;
    dcache2mem_wdata    = w_mem ? r_req.wdata : '0;
    dcache2mem_sel_byte = w_mem ? r_req.sel : '0;
    dcache2stb_ack      = r_state == S_ACK;
    dcache2stb_busy     = r_state != S_IDLE;
  end
  dcache_word_array #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BYTE_SEL_WIDTH(BYTE_SEL_WIDTH), .NUM_LINES(NUM_LINES)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (r_state == S_LOOKUP && w_is_wr),
    .i_wr_waddr(r_req.addr[ADDR_WIDTH-1:2]),
    .i_wr_data (r_req.wdata),
    .i_wr_sel  (r_req.sel),
    .i_rd_waddr(lsu2dcache_lk_addr[ADDR_WIDTH-1:2]),
    .o_rd_hit  (dcache2lsu_lk_hit),
    .o_rd_data (dcache2lsu_lk_rdata)
  );
endmodule

// File: tb/tb_stb_dcache_responder.sv
// tb_stb_dcache_responder: directed checks of store drain, write-through timing, lookup and reset
module tb_stb_dcache_responder;
  logic        clk = 0, rst = 1;
  logic [31:0] stb_addr = 0, stb_wdata = 0, lk_addr = 0;
  logic [3:0]  stb_sel = 0;
  logic        stb_w_en = 0, stb_req = 0, dmem_sel = 0, mem_ack = 0;
  logic        stb_ack, mem_req, lk_hit, busy;
  logic [31:0] mem_addr, mem_wdata, lk_rdata;
  logic [3:0]  mem_sel;
  int tests = 0, fails = 0;

  stb_dcache_responder dut (
    .clk(clk), .rst(rst),
    .stb2dcache_addr(stb_addr), .stb2dcache_wdata(stb_wdata), .stb2dcache_sel_byte(stb_sel),
    .stb2dcache_w_en(stb_w_en), .stb2dcache_req(stb_req), .dmem_sel_i(dmem_sel),
    .dcache2stb_ack(stb_ack), .dcache2mem_addr(mem_addr), .dcache2mem_wdata(mem_wdata),
    .dcache2mem_sel_byte(mem_sel), .dcache2mem_req(mem_req), .mem2dcache_ack(mem_ack),
    .lsu2dcache_lk_addr(lk_addr), .dcache2lsu_lk_hit(lk_hit), .dcache2lsu_lk_rdata(lk_rdata),
    .dcache2stb_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input logic hit, input logic [31:0] d);
    lk_addr = a;
    tick();
    chk($sformatf("lk_hit@%h", a), {31'd0, lk_hit}, {31'd0, hit});
    chk($sformatf("lk_rdata@%h", a), lk_rdata, d);
  endtask

  // req held through the whole transaction; stalls = MEM_WR cycles before mem ack is driven
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int stalls);
    stb_addr = a; stb_wdata = d; stb_sel = s; stb_w_en = 1; dmem_sel = 1; stb_req = 1;
    tick();
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("c2_mem_req", {31'd0, mem_req}, 32'd1);
    chk("c2_mem_addr", mem_addr, {a[31:2], 2'b00});
    chk("c2_mem_wdata", mem_wdata, d);
    chk("c2_mem_sel", {28'd0, mem_sel}, {28'd0, s});
    for (int i = 0; i < stalls; i++) begin
      tick();
      chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall_mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("stall_mem_wdata", mem_wdata, d);
      chk("stall_ack", {31'd0, stb_ack}, 32'd0);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("ack_pulse", {31'd0, stb_ack}, 32'd1);
    chk("ack_mem_req", {31'd0, mem_req}, 32'd0);
    stb_req = 0;
    tick();
    chk("ack_drop", {31'd0, stb_ack}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_ack", {31'd0, stb_ack}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    lookup(32'h0, 1'b0, 32'h0);

    store(32'h0, 32'hAAAA_BBBB, 4'hF, 0);
    lookup(32'h0, 1'b1, 32'hAAAA_BBBB);

    store(32'h6, 32'hCCCC_DDDD, 4'b0011, 0);
    lookup(32'h4, 1'b0, 32'h0);
    store(32'h4, 32'h1111_2222, 4'hF, 0);
    store(32'h4, 32'h00EE_0000, 4'b0100, 0);
    lookup(32'h4, 1'b1, 32'h11EE_2222);

    store(32'h40, 32'hDEAD_BEEF, 4'hF, 0);
    lookup(32'h0, 1'b0, 32'h0);
    lookup(32'h40, 1'b1, 32'hDEAD_BEEF);

    store(32'h40, 32'hFFFF_FFFF, 4'h0, 0);
    lookup(32'h40, 1'b1, 32'hDEAD_BEEF);

    store(32'h8, 32'h1234_5678, 4'hF, 5);
    lookup(32'h8, 1'b1, 32'h1234_5678);

    stb_addr = 32'hC; stb_wdata = 32'h5555_6666; stb_sel = 4'hF; stb_w_en = 1; dmem_sel = 1; stb_req = 1;
    tick();
    tick();
    chk("rstmid_mem_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1; stb_req = 0;
    tick();
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_ack", {31'd0, stb_ack}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    rst = 0;
    tick();
    chk("rstmid_no_ack", {31'd0, stb_ack}, 32'd0);
    lookup(32'h4, 1'b0, 32'h0);
    lookup(32'h8, 1'b0, 32'h0);
    lookup(32'hC, 1'b0, 32'h0);

    stb_addr = 32'h10; stb_wdata = 32'h7777_8888; stb_sel = 4'hF; stb_w_en = 0; dmem_sel = 1; stb_req = 1;
    tick();
    chk("rd_c1_ack", {31'd0, stb_ack}, 32'd0);
    tick();
    chk("rd_c2_ack", {31'd0, stb_ack}, 32'd1);
    chk("rd_c2_mem_req", {31'd0, mem_req}, 32'd0);
    stb_req = 0;
    tick();
    chk("rd_ack_drop", {31'd0, stb_ack}, 32'd0);
    lookup(32'h10, 1'b0, 32'h0);

    stb_w_en = 1; dmem_sel = 0; stb_req = 1;
    tick();
    tick();
    chk("nodmem_ack", {31'd0, stb_ack}, 32'd1);
    chk("nodmem_mem_req", {31'd0, mem_req}, 32'd0);
    stb_req = 0;
    tick();
    lookup(32'h10, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
